axc_abs_diff_resp_checker: RTL

// Response-side companion to the approximate abs-diff circuits: sequences operand vectors into a

---
 rtl/axc_abs_diff_resp_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axc_abs_diff_resp_checker.sv
// Response checker for a combinational 8-in/4-out approximate abs-diff DUT: drives operand vectors,
// scores each 4-bit result against exact |a-b| and accumulates error statistics on-chip.
// Optional macro AXC_CHK_FAIL_CAPTURE_EN adds capture of the first violating vector and result.
module axc_abs_diff_resp_checker #(
   parameter logic [7:0] FIRST_VEC = 8'h00,
   parameter int         NUM_VEC   = 256,
   parameter int         SETTLE    = 1,
   parameter logic [3:0] WC        = 4'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  dut_pi,
   input  logic [3:0]  dut_po,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [8:0]  vec_cnt,
   output logic [8:0]  err_cnt,
   output logic [3:0]  max_err,
   output logic [15:0] sum_err
`ifdef AXC_CHK_FAIL_CAPTURE_EN
   ,
   output logic        fail_valid,
   output logic [7:0]  fail_vec,
   output logic [3:0]  fail_po
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [8:0] LAST_CNT = 9'(NUM_VEC - 1);
   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t      state;
   logic [7:0]  vec;
   logic [3:0]  wait_cnt;

   logic [3:0]  op_a;
   logic [3:0]  op_b;
   logic [3:0]  golden;
   logic [3:0]  err;
   logic        violate;

   // Magnitudes are taken by ordered subtraction so neither golden nor err ever wraps.
   assign op_a    = vec[7:4];
   assign op_b    = vec[3:0];
   assign golden  = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
   assign err     = (dut_po >= golden) ? (dut_po - golden) : (golden - dut_po);
   assign violate = (err > WC);

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         vec      <= 8'h00;
         wait_cnt <= 4'd0;
         dut_pi   <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         vec_cnt  <= 9'd0;
         err_cnt  <= 9'd0;
         max_err  <= 4'd0;
         sum_err  <= 16'd0;
`ifdef AXC_CHK_FAIL_CAPTURE_EN
         fail_valid <= 1'b0;
         fail_vec   <= 8'h00;
         fail_po    <= 4'd0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_DRIVE;
                  vec     <= FIRST_VEC;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  vec_cnt <= 9'd0;
                  err_cnt <= 9'd0;
                  max_err <= 4'd0;
                  sum_err <= 16'd0;
`ifdef AXC_CHK_FAIL_CAPTURE_EN
                  fail_valid <= 1'b0;
                  fail_vec   <= 8'h00;
                  fail_po    <= 4'd0;
`endif
               end
            end
            S_DRIVE: begin
               dut_pi   <= vec;
               wait_cnt <= SETTLE_L - 4'd1;
               state    <= (SETTLE_L == 4'd0) ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= S_SAMPLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_SAMPLE: begin
               vec_cnt <= vec_cnt + 9'd1;
               sum_err <= sum_err + {12'd0, err};
               err_cnt <= err_cnt + {8'd0, violate};
               if (err > max_err) begin
                  max_err <= err;
               end
`ifdef AXC_CHK_FAIL_CAPTURE_EN
               if (violate && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_vec   <= vec;
                  fail_po    <= dut_po;
               end
`endif
               // The last vector is compared before the increment so vec never steps past it.
               if (vec_cnt == LAST_CNT) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == 9'd0) && !violate;
               end else begin
                  vec   <= vec + 8'd1;
                  state <= S_DRIVE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
